mse_link_master: RTL and testbench

Avalon-MM slave to serial-link bridge, the initiator end of the MSE serial link. It accepts single-word read/write transactions on an `avs_ctrl` slave port and shifts each one out as a 48-bit command frame on `sdo`/`sle`. It then waits for the far-end host to raise `srdy`, and for reads shifts the 32-bit response in on `sdi`. It sits in the local Qsys system and drives the serial pins that connect to the remote `mse_host`, which replays frames as Avalon master cycles.

---
 rtl/mse_link_master.sv | 141 ++++++++++++++
 tb/tb_mse_link_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mse_link_master.sv
// Purpose : Avalon-MM slave to MSE serial-link bridge; sends each read/write as a 48-bit frame on sdo/sle.
// Latency : write DONE 50 cycles after acceptance with srdy in the first wait cycle; read DONE at +82.
// Backpressure: waitrequest is held high while a request is pending, except in the single DONE cycle.
//
// Ports:
//   clk, reset_n             clock and synchronous active-low reset
//   avs_ctrl_*               Avalon-MM slave port (single-word read/write)
//   sdo, sle                 serial command frame out, MSB first, sle high for 48 cycles
//   srdy, sdi                far-end ready strobe and serial read-response data in
//   timeout_err              one-cycle pulse in the DONE cycle of a timed-out transaction
module mse_link_master #(
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  avs_ctrl_address,
    input  logic [31:0] avs_ctrl_writedata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic [31:0] avs_ctrl_readdata,
    output logic        avs_ctrl_waitrequest,
    output logic        sdo,
    output logic        sle,
    input  logic        srdy,
    input  logic        sdi,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT_RDY,
        S_RX,
        S_DONE
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [47:0] shreg;
    logic [5:0]  bit_cnt;
    logic [15:0] tmo_cnt;
    logic        is_wr;
    logic        req;
    logic [47:0] frame;

    assign req = avs_ctrl_read | avs_ctrl_write;

    // A simultaneous read and write is sent as a write; read frames carry zero data.
    assign frame = {avs_ctrl_write, avs_ctrl_byteenable, 3'b000, avs_ctrl_address,
                    avs_ctrl_write ? avs_ctrl_writedata : 32'h0};

    assign avs_ctrl_waitrequest = req & (state != S_DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (req) state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_cnt == 6'd47) state_nx = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                // srdy wins over an expiring timeout in the same cycle.
                if (srdy)                     state_nx = is_wr ? S_DONE : S_RX;
                else if (tmo_cnt == TMO_LAST) state_nx = S_DONE;
            end
            S_RX: begin
                if (bit_cnt == 6'd31) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            shreg             <= '0;
            bit_cnt           <= '0;
            tmo_cnt           <= '0;
            is_wr             <= 1'b0;
            sdo               <= 1'b0;
            sle               <= 1'b0;
            avs_ctrl_readdata <= '0;
            timeout_err       <= 1'b0;
        end else begin
            state       <= state_nx;
            timeout_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        // Bit 47 goes straight to sdo; the register keeps the rest pre-shifted.
                        sdo     <= frame[47];
                        shreg   <= {frame[46:0], 1'b0};
                        sle     <= 1'b1;
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                        is_wr   <= avs_ctrl_write;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt == 6'd47) begin
                        sle     <= 1'b0;
                        sdo     <= 1'b0;
                        tmo_cnt <= '0;
                    end else begin
                        sdo     <= shreg[47];
                        shreg   <= {shreg[46:0], 1'b0};
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                S_WAIT_RDY: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (srdy) begin
                        bit_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        if (!is_wr) avs_ctrl_readdata <= ERR_DATA;
                    end
                end
                S_RX: begin
                    // First sample ends up in bit 31 after 32 shifts.
                    avs_ctrl_readdata <= {avs_ctrl_readdata[30:0], sdi};
                    bit_cnt           <= bit_cnt + 6'd1;
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mse_link_master.sv
// Purpose : self-checking bench for mse_link_master against a transaction-level link model.
// Latency : expected DONE cycle derived from frame length, srdy delay and response length.
// Backpressure: holds each request until waitrequest drops, optionally across DONE.
module tb_mse_link_master;

    localparam int          TO   = 16;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  avs_ctrl_address;
    logic [31:0] avs_ctrl_writedata;
    logic [3:0]  avs_ctrl_byteenable;
    logic        avs_ctrl_write;
    logic        avs_ctrl_read;
    logic [31:0] avs_ctrl_readdata;
    logic        avs_ctrl_waitrequest;
    logic        sdo;
    logic        sle;
    logic        srdy;
    logic        sdi;
    logic        timeout_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rd;

    mse_link_master #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .avs_ctrl_address     (avs_ctrl_address),
        .avs_ctrl_writedata   (avs_ctrl_writedata),
        .avs_ctrl_byteenable  (avs_ctrl_byteenable),
        .avs_ctrl_write       (avs_ctrl_write),
        .avs_ctrl_read        (avs_ctrl_read),
        .avs_ctrl_readdata    (avs_ctrl_readdata),
        .avs_ctrl_waitrequest (avs_ctrl_waitrequest),
        .sdo                  (sdo),
        .sle                  (sle),
        .srdy                 (srdy),
        .sdi                  (sdi),
        .timeout_err          (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction. Cycle 0 presents the request with the DUT idle, so the
    // frame should occupy cycles 1..48. d is the srdy delay in wait cycles
    // (d < 0: srdy never comes). Request fields are scrambled after cycle 0.
    task automatic run_txn(input logic wr, input logic rd, input logic [7:0] addr,
                           input logic [31:0] data, input logic [3:0] be, input int d,
                           input logic [31:0] hdata, input bit stray, input bit hold);
        logic [47:0] exp_frame;
        logic [47:0] got_frame;
        logic [31:0] rd_at_done;
        int          exp_done;
        int          sle_cnt;
        int          first_sle;
        int          done_t;
        int          bad_sdo;
        int          tout_cnt;
        logic        tout_at_done;

        exp_frame = {wr, be, 3'b000, addr, (wr ? data : 32'h0)};
        if (d < 0)   exp_done = 49 + TO;
        else if (wr) exp_done = 50 + d;
        else         exp_done = 82 + d;
        if (!wr) exp_rd = (d < 0) ? ERRD : hdata;

        got_frame = '0; rd_at_done = '0; sle_cnt = 0; first_sle = -1; done_t = -1;
        bad_sdo = 0; tout_cnt = 0; tout_at_done = 1'b0;

        for (int t = 0; t < exp_done + 40; t++) begin
            @(posedge clk); #1;
            reset_n = 1'b1;
            if (t == 0) begin
                avs_ctrl_write      = wr;
                avs_ctrl_read       = rd;
                avs_ctrl_address    = addr;
                avs_ctrl_writedata  = data;
                avs_ctrl_byteenable = be;
            end else begin
                avs_ctrl_address    = 8'($urandom);
                avs_ctrl_writedata  = $urandom;
                avs_ctrl_byteenable = 4'($urandom);
            end
            srdy = 1'b0;
            if (stray && t >= 1 && t <= 48) srdy = 1'b1;
            if (d >= 0 && t == 49 + d) srdy = 1'b1;
            if (d >= 0 && !wr && t >= 50 + d) srdy = 1'($urandom);
            if (d >= 0 && !wr && t >= 50 + d && t <= 81 + d) sdi = hdata[81 + d - t];
            else                                             sdi = 1'($urandom);
            @(negedge clk);
            if (sle) begin
                if (first_sle < 0) first_sle = t;
                if (sle_cnt < 48) got_frame[47 - sle_cnt] = sdo;
                sle_cnt++;
            end else if (sdo) begin
                bad_sdo++;
            end
            if (timeout_err) tout_cnt++;
            if (!avs_ctrl_waitrequest) begin
                done_t       = t;
                rd_at_done   = avs_ctrl_readdata;
                tout_at_done = timeout_err;
            end
            if (done_t >= 0) break;
        end

        if (!hold) begin
            @(posedge clk); #1;
            avs_ctrl_write = 1'b0;
            avs_ctrl_read  = 1'b0;
            srdy           = 1'b0;
            @(negedge clk);
            if (timeout_err) tout_cnt++;
            check("post_done_sle", sle, 1'b0);
        end

        check("first_sle_cycle", first_sle, 1);
        check("sle_length", sle_cnt, 48);
        check("frame", got_frame, exp_frame);
        check("sdo_outside_frame", bad_sdo, 0);
        check("done_cycle", done_t, exp_done);
        check("readdata", rd_at_done, exp_rd);
        check("timeout_at_done", tout_at_done, (d < 0));
        check("timeout_pulses", tout_cnt, (d < 0) ? 1 : 0);
    endtask

    initial begin
        int wr_lo;
        int r;
        int kind;
        int dly;

        reset_n             = 1'b0;
        avs_ctrl_write      = 1'b1;
        avs_ctrl_read       = 1'b0;
        avs_ctrl_address    = 8'h12;
        avs_ctrl_writedata  = 32'h1234_5678;
        avs_ctrl_byteenable = 4'hF;
        srdy                = 1'b0;
        sdi                 = 1'b0;
        exp_rd              = '0;

        // Reset held with a write pending.
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            srdy = 1'($urandom);
            sdi  = 1'($urandom);
            @(negedge clk);
            check("rst_sle", sle, 1'b0);
            check("rst_sdo", sdo, 1'b0);
            check("rst_tout", timeout_err, 1'b0);
            check("rst_readdata", avs_ctrl_readdata, 32'h0);
            check("rst_waitreq", avs_ctrl_waitrequest, 1'b1);
        end

        // Write, srdy 3 cycles after sle falls.
        run_txn(1'b1, 1'b0, 8'h12, 32'h1234_5678, 4'hF, 3, 32'h0, 1'b0, 1'b0);
        // Read, srdy in first wait cycle.
        run_txn(1'b0, 1'b1, 8'hA5, 32'h5555_AAAA, 4'hF, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
        // Timed-out read.
        run_txn(1'b0, 1'b1, 8'h40, 32'h0, 4'h3, -1, 32'h0, 1'b0, 1'b0);
        // Stray srdy during the frame, real one after 5 quiet wait cycles.
        run_txn(1'b1, 1'b0, 8'h77, 32'h0BAD_F00D, 4'h9, 5, 32'h0, 1'b1, 1'b0);
        // Simultaneous read and write is a write.
        run_txn(1'b1, 1'b1, 8'h01, 32'hFFFF_0000, 4'hC, 2, 32'h0, 1'b0, 1'b0);
        // Back-to-back: write held across DONE.
        run_txn(1'b1, 1'b0, 8'h3C, 32'hA5A5_5A5A, 4'hF, 1, 32'h0, 1'b0, 1'b1);

        // Second frame of the pair, reset at bit 20.
        wr_lo = 0;
        for (int t = 0; t < 27; t++) begin
            @(posedge clk); #1;
            if (t == 0) begin
                avs_ctrl_write      = 1'b1;
                avs_ctrl_read       = 1'b0;
                avs_ctrl_address    = 8'h3D;
                avs_ctrl_writedata  = 32'h0123_4567;
                avs_ctrl_byteenable = 4'hF;
            end
            if (t == 21) reset_n = 1'b0;
            if (t == 24) begin
                reset_n        = 1'b1;
                avs_ctrl_write = 1'b0;
            end
            srdy = 1'($urandom);
            @(negedge clk);
            if (t < 24 && !avs_ctrl_waitrequest) wr_lo++;
            if (t == 0)  check("b2b_idle_gap", sle, 1'b0);
            if (t == 1)  check("b2b_frame_start", sle, 1'b1);
            if (t == 1)  check("b2b_first_bit", sdo, 1'b1);
            if (t == 21) check("abort_sle_before", sle, 1'b1);
            if (t == 22) check("abort_sle_drop", sle, 1'b0);
            if (t == 23) check("abort_sdo", sdo, 1'b0);
            if (t == 23) check("abort_readdata", avs_ctrl_readdata, 32'h0);
            if (t == 25) check("abort_stays_idle", sle, 1'b0);
        end
        check("abort_no_done", wr_lo, 0);
        exp_rd = '0;

        // Randomized transactions.
        for (int n = 0; n < 30; n++) begin
            r    = int'($urandom_range(0, 9));
            dly  = (r == 0) ? -1 : int'($urandom_range(0, 6));
            kind = int'($urandom_range(0, 2));
            run_txn((kind != 1), (kind != 0), 8'($urandom), $urandom, 4'($urandom),
                    dly, $urandom, 1'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
